counter_seq_arbiter: RTL
========================

Name: counter_seq_arbiter

Overview:
- Shares one threebitcounter instance among NREQ requesters.
- Each requester asks for "load start value, then increment N times, return final value".
- Block arbitrates round-robin and drives the counter's ld/inc/data_in for the granted requester.
- Returns the counter's data_out with a one-cycle done pulse. Sits beside the counter in the top level and replaces the tied-off ld/inc controls.

Parameters:
- WIDTH, 3, counter data width; must match the counter instance.
- NREQ, 4, number of requesters, 2..8.
- CNTW, 4, width of each increment-count field; max increments per job = 2**CNTW-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester job request, level.
- start_val  input  NREQ*WIDTH  flat bus; field i = start value of requester i.
- num_incs  input  NREQ*CNTW  flat bus; field i = increment count of requester i.
- gnt  output  NREQ  one-hot owner; asserted LOAD through DONE.
- done  output  NREQ  one-cycle completion pulse, bit of owner.
- result  output  WIDTH  final counter value; valid only while done is nonzero, else 0.
- busy  output  1  high whenever state is not IDLE.
- cnt_ld  output  1  to counter ld.
- cnt_inc  output  1  to counter inc.
- cnt_data_in  output  WIDTH  to counter data_in.
- cnt_data_out  input  WIDTH  from counter data_out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt, done, cnt_ld, cnt_inc, cnt_data_in, busy all 0.
  - rr pointer=0; internal start/remaining registers 0.
  - Reset mid-job aborts with no done pulse. Counter reset is not driven by this block.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req bit is set, pick the winner: first set bit searching from ptr upward, wrapping.
  - Latch the winner's start_val and num_incs fields; set gnt one-hot; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - cnt_ld=1 and cnt_data_in=latched start, for exactly one cycle.
  - Next state is COUNT if remaining>0, otherwise DONE.
- COUNT:
  - cnt_inc=1 every cycle; remaining decrements each cycle.
  - When remaining==1 in this cycle, next state is DONE.
  - Total cnt_inc cycles equal the latched num_incs.
- DONE:
  - done[owner]=1 and result=cnt_data_out, combinational and gated by state.
  - Update ptr=(owner+1) mod NREQ. Clear gnt on exit. Next state is IDLE.
- Outputs cnt_ld, cnt_inc, gnt, done and busy are decoded from registered state; no glitch paths from req.
- Counter is registered with a one-cycle update, so the DONE value equals (start + n) mod 2**WIDTH.
- Latency: req seen in IDLE at cycle t gives
  - gnt/LOAD at t+1
  - inc at t+2..t+1+n
  - done at t+2+n
  - IDLE at t+3+n
  - next grant earliest at t+4+n.
- n=0: LOAD then DONE; result=start.
- Wrap-around: width overflow is handled by the counter modulo 2**WIDTH; the block does no arithmetic on data.
- Inputs after grant:
  - Owner dropping req, or changing start_val/num_incs, after grant has no effect; the job completes on latched values.
  - Requests are not sampled outside IDLE.
  - A requester must drop req within one cycle of its done pulse or it re-enters arbitration.
- Simultaneous requests: only one grant per IDLE cycle. Round-robin guarantees each pending requester is served within NREQ jobs.
- cnt_ld and cnt_inc are never both high.

Decomposition:
- Shared package counter_seq_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_LOAD=2'd1, ST_COUNT=2'd2, ST_DONE=2'd3
  - default WIDTH and CNTW constants.
- One sub-module, rr_arbiter (NREQ): inputs req and ptr, output one-hot grant plus encoded index; purely combinational.
- FSM, latches and pointer stay in the top module.

Test Plan:
- Single job: req[0], start=3, n=2 with threebitcounter attached -> gnt[0] for 4 cycles, ld 1 cycle, inc 2 cycles, done[0] with result=5.
- Wrap: req[2], start=6, n=5 -> 5 inc cycles, result=3; busy high 7 cycles.
- Zero increments: req[1], start=4, n=0 -> LOAD then DONE, no cnt_inc, result=4.
- Fairness: req=4'b1111 held continuously, each n=1 -> grant order 0,1,2,3,0; each done spaced 4 cycles.
- Robustness: owner drops req and changes start_val mid-COUNT -> job completes with latched values and correct result.
- Async reset: rst_n=0 mid-COUNT -> all outputs 0 immediately, no done pulse; after release, req[3] is granted before req[0] only if req[0] is absent (ptr=0).

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared constants and state encoding for the counter sequencing arbiter.
package counter_seq_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_CNTW  = 4;
    localparam int DEF_NREQ  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_COUNT = ST_COUNT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] index,
    output logic                    any
);

    localparam int PTRW = $clog2(NREQ);

    logic found;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = PTRW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/counter_seq_arbiter.sv
// Shares one counter among NREQ requesters: load start value, increment n times,
// return the final counter value with a one-cycle done pulse.
module counter_seq_arbiter
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] start_val,
    input  logic [NREQ*CNTW-1:0]  num_incs,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  cnt_ld,
    output logic                  cnt_inc,
    output logic [WIDTH-1:0]      cnt_data_in,
    input  logic [WIDTH-1:0]      cnt_data_out
);

    localparam int PTRW = $clog2(NREQ);

    state_t            state_reg;
    state_t            state_next;
    logic [PTRW-1:0]   ptr_reg;
    logic [PTRW-1:0]   owner_reg;
    logic [PTRW-1:0]   ptr_next;
    logic [NREQ-1:0]   gnt_reg;
    logic [WIDTH-1:0]  start_reg;
    logic [CNTW-1:0]   remain_reg;

    logic [WIDTH-1:0]  start_arr [NREQ];
    logic [CNTW-1:0]   incs_arr  [NREQ];

    logic [NREQ-1:0]   win_grant;
    logic [PTRW-1:0]   win_index;
    logic              win_any;

    // Split the flat request buses into per-requester fields.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign start_arr[gi] = start_val[gi*WIDTH +: WIDTH];
            assign incs_arr[gi]  = num_incs[gi*CNTW +: CNTW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (win_grant),
        .index (win_index),
        .any   (win_any)
    );

    // Pointer moves to the requester just after the one being served.
    always_comb begin
        ptr_next = owner_reg + PTRW'(1);
        if (owner_reg == PTRW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    // State register plus job latches; requests are only sampled in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            gnt_reg    <= '0;
            start_reg  <= '0;
            remain_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (win_any) begin
                        gnt_reg    <= win_grant;
                        owner_reg  <= win_index;
                        start_reg  <= start_arr[win_index];
                        remain_reg <= incs_arr[win_index];
                    end
                end
                S_COUNT: begin
                    remain_reg <= remain_reg - CNTW'(1);
                end
                S_DONE: begin
                    gnt_reg <= '0;
                    ptr_reg <= ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode; a zero-increment job skips COUNT entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (win_any) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (remain_reg != '0) begin
                    state_next = S_COUNT;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_COUNT: begin
                if (remain_reg == CNTW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs come from registered state only, so req cannot glitch them.
    always_comb begin
        busy        = (state_reg != S_IDLE);
        cnt_ld      = (state_reg == S_LOAD);
        cnt_inc     = (state_reg == S_COUNT);
        cnt_data_in = (state_reg == S_LOAD) ? start_reg : '0;
        gnt         = gnt_reg;
        done        = (state_reg == S_DONE) ? gnt_reg : '0;
        result      = (state_reg == S_DONE) ? cnt_data_out : '0;
    end

endmodule
